// File: rtl/proj_pkg.sv
// Shared types and helper constants for the k-mer minimiser selector.
//   state_t  : scan FSM states
//   cand_t   : one candidate slot {valid, hash, index}; the hash and index
//              fields are sized for the widest supported configuration and
//              hold zero-extended values
//   num_kmers: number of k-mer positions in a fragment
package proj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Upper bounds on the per-instance HASH_BITS / INDICE_LEN parameters.
   localparam int HASH_W_MAX = 16;
   localparam int IDX_W_MAX  = 8;

   // Default-parameter derived constants.
   localparam int DEF_FRAG_SIZE = 8;
   localparam int DEF_KMER_SIZE = 4;
   localparam int DEF_NUM_KMERS = DEF_FRAG_SIZE - DEF_KMER_SIZE + 1;

   typedef struct packed {
      logic                  vld;
      logic [HASH_W_MAX-1:0] hash;
      logic [IDX_W_MAX-1:0]  idx;
   } cand_t;

   function automatic int num_kmers(input int frag_size, input int kmer_size);
      return frag_size - kmer_size + 1;
   endfunction

endpackage

// File: rtl/kmer_hash.sv
// Combinational k-mer hash: ((kmer * HASH_MULT) mod 2^HASH_BITS) ^ HASH_SEED.
//   i_kmer : packed k-mer value (KMER_BITS wide)
//   o_hash : HASH_BITS-wide hash
module kmer_hash #(
   parameter int                    KMER_BITS = 8,
   parameter int                    HASH_BITS = 8,
   parameter int unsigned           HASH_MULT = 157,
   parameter logic [HASH_BITS-1:0]  HASH_SEED = 8'h5A
) (
   input  logic [KMER_BITS-1:0] i_kmer,
   output logic [HASH_BITS-1:0] o_hash
);

   // Product is computed wide enough never to overflow; only the low
   // HASH_BITS are kept, which is the mod 2^HASH_BITS.
   localparam int PW = KMER_BITS + 32;

   logic [PW-1:0] w_prod;

   assign w_prod = PW'(i_kmer) * PW'(HASH_MULT);
   assign o_hash = w_prod[HASH_BITS-1:0] ^ HASH_SEED;

endmodule

// File: rtl/kmer_min_selector.sv
// Scans a latched fragment one k-mer position per cycle, hashes each k-mer
// and keeps the INDICES_COUNT positions with the smallest hashes in a sorted
// candidate list (stable on ties). The result is published once per scan.
//   clk, rst         : clock, synchronous active-high reset
//   in_fragment      : packed bases, base b at [b*BASE_LEN +: BASE_LEN]
//   start            : one-cycle scan request, honoured only in IDLE
//   busy             : high in SCAN and DONE
//   out_kmer_indices : selected positions, slot 0 = smallest hash; feeds
//                      proj_extender.in_kmer_indices
//   valid_indices    : one-cycle strobe when out_kmer_indices is updated;
//                      feeds proj_extender.valid_indices
module kmer_min_selector
   import proj_pkg::*;
#(
   parameter int                   FRAG_SIZE     = 8,
   parameter int                   BASE_LEN      = 2,
   parameter int                   FRAG_LEN_BITS = 16,
   parameter int                   KMER_SIZE     = 4,
   parameter int                   INDICES_COUNT = 4,
   parameter int                   INDICE_LEN    = 3,
   parameter int                   HASH_BITS     = 8,
   parameter int unsigned          HASH_MULT     = 157,
   parameter logic [HASH_BITS-1:0] HASH_SEED     = 8'h5A
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [FRAG_LEN_BITS-1:0]                 in_fragment,
   input  logic                                     start,
   output logic                                     busy,
   output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] out_kmer_indices,
   output logic                                     valid_indices
);

   localparam int NUM_KMERS = num_kmers(FRAG_SIZE, KMER_SIZE);
   localparam int KMER_BITS = KMER_SIZE * BASE_LEN;

   // Parameter sanity checks at elaboration.
   if (FRAG_LEN_BITS != FRAG_SIZE * BASE_LEN) begin : g_chk_frag
      $error("FRAG_LEN_BITS must equal FRAG_SIZE*BASE_LEN");
   end
   if (NUM_KMERS < INDICES_COUNT) begin : g_chk_cnt
      $error("NUM_KMERS must be >= INDICES_COUNT");
   end
   if ((1 << INDICE_LEN) < NUM_KMERS) begin : g_chk_idx
      $error("INDICE_LEN too narrow for NUM_KMERS");
   end
   if (HASH_BITS > HASH_W_MAX || INDICE_LEN > IDX_W_MAX) begin : g_chk_slot
      $error("HASH_BITS/INDICE_LEN exceed candidate slot field widths");
   end

   state_t                                  r_state, w_state_nxt;
   logic [INDICE_LEN-1:0]                   r_pos;
   logic [FRAG_LEN_BITS-1:0]                r_frag;
   cand_t [INDICES_COUNT-1:0]               r_slot;
   logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] r_out;
   logic                                    r_valid;

   logic [NUM_KMERS-1:0][KMER_BITS-1:0]     w_kmers;
   logic [KMER_BITS-1:0]                    w_kmer;
   logic [HASH_BITS-1:0]                    w_hash;
   logic                                    w_last;
   cand_t                                   w_new;
   logic [INDICES_COUNT-1:0]                w_gt;
   cand_t [INDICES_COUNT-1:0]               w_slot_nxt;

   // ---------------------------------------------------------------
   // K-mer extraction and hashing
   // ---------------------------------------------------------------
   for (genvar g = 0; g < NUM_KMERS; g++) begin : g_kmer
      assign w_kmers[g] = r_frag[g*BASE_LEN +: KMER_BITS];
   end

   always_comb begin
      w_kmer = '0;
      for (int i = 0; i < NUM_KMERS; i++) begin
         if (r_pos == INDICE_LEN'(i)) w_kmer = w_kmers[i];
      end
   end

   kmer_hash #(
      .KMER_BITS (KMER_BITS),
      .HASH_BITS (HASH_BITS),
      .HASH_MULT (HASH_MULT),
      .HASH_SEED (HASH_SEED)
   ) u_hash (
      .i_kmer (w_kmer),
      .o_hash (w_hash)
   );

   assign w_new.vld  = 1'b1;
   assign w_new.hash = HASH_W_MAX'(w_hash);
   assign w_new.idx  = IDX_W_MAX'(r_pos);

   // ---------------------------------------------------------------
   // Compare-and-shift insertion. The list is sorted with invalid slots
   // at the tail, so w_gt is a thermometer: the first set bit is the
   // insertion point, slots after it take their predecessor. Strict '>'
   // keeps an equal-hash earlier position ahead of the new one.
   // ---------------------------------------------------------------
   for (genvar i = 0; i < INDICES_COUNT; i++) begin : g_ins
      assign w_gt[i] = !r_slot[i].vld || (r_slot[i].hash > w_new.hash);
      if (i == 0) begin : g_head
         assign w_slot_nxt[i] = w_gt[i] ? w_new : r_slot[i];
      end else begin : g_body
         assign w_slot_nxt[i] = !w_gt[i]    ? r_slot[i]   :
                                 w_gt[i-1]  ? r_slot[i-1] : w_new;
      end
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   assign w_last = (r_pos == INDICE_LEN'(NUM_KMERS - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_SCAN;
         ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE:             w_state_nxt = ST_IDLE;
         default:             w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos   <= '0;
         r_frag  <= '0;
         r_slot  <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_frag <= in_fragment;
                  r_pos  <= '0;
                  r_slot <= '0;
               end
            end
            ST_SCAN: begin
               r_slot <= w_slot_nxt;
               r_pos  <= r_pos + 1'b1;
            end
            ST_DONE: begin
               for (int i = 0; i < INDICES_COUNT; i++)
                  r_out[i] <= r_slot[i].idx[INDICE_LEN-1:0];
            end
            default: ;
         endcase
      end
   end

   assign busy             = (r_state != ST_IDLE);
   assign out_kmer_indices = r_out;
   assign valid_indices    = r_valid;

endmodule

// File: tb/tb_kmer_min_selector.sv
module tb_kmer_min_selector;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       frag0, frag1;
   logic              start0, start1;
   logic              busy0, busy1, vld0, vld1;
   logic [3:0][2:0]   out0, out1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Default parameters.
   kmer_min_selector dut0 (
      .clk (clk), .rst (rst), .in_fragment (frag0), .start (start0),
      .busy (busy0), .out_kmer_indices (out0), .valid_indices (vld0)
   );

   // Identity hash: hash == k-mer value.
   kmer_min_selector #(.HASH_MULT (1), .HASH_SEED (8'h00)) dut1 (
      .clk (clk), .rst (rst), .in_fragment (frag1), .start (start1),
      .busy (busy1), .out_kmer_indices (out1), .valid_indices (vld1)
   );

   typedef struct {
      bit          which;
      logic [15:0] frag;
      logic [11:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] pk(input int s0, input int s1, input int s2, input int s3);
      return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
   endfunction

   // Reference: hash every position, then pick the four smallest by
   // (hash, position) order.
   function automatic logic [11:0] model(input logic [15:0] frag, input bit which);
      int h[5];
      bit used[5];
      int sel[4];
      int mult = which ? 1 : 157;
      int seed = which ? 0 : 'h5A;
      for (int p = 0; p < 5; p++) begin
         int kv = int'((frag >> (2 * p)) & 16'hFF);
         h[p] = ((kv * mult) % 256) ^ seed;
         used[p] = 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
         int best = -1;
         for (int p = 0; p < 5; p++)
            if (!used[p] && (best < 0 || h[p] < h[best])) best = p;
         used[best] = 1'b1;
         sel[r] = best;
      end
      return pk(sel[0], sel[1], sel[2], sel[3]);
   endfunction

   function automatic logic [13:0] status(input bit which);
      return which ? {busy1, vld1, out1} : {busy0, vld0, out0};
   endfunction

   // Full scan with a fixed schedule; optionally scrambles in_fragment
   // right after start to prove the fragment was latched.
   task automatic do_scan(input bit which, input logic [15:0] frag,
                          input logic [11:0] exp, input bit scramble, input string nm);
      logic [13:0] st;
      if (which) begin frag1 = frag; start1 = 1'b1; end
      else       begin frag0 = frag; start0 = 1'b1; end
      tick();
      start0 = 1'b0; start1 = 1'b0;
      if (scramble) begin frag0 = ~frag ^ 16'h5A5A; frag1 = ~frag ^ 16'h5A5A; end
      for (int k = 1; k <= 6; k++) begin
         tick();
         st = status(which);
         if (k < 6) chk({nm, " busy/valid mid-scan"}, 32'(st[13:12]), 32'b10);
      end
      chk({nm, " busy/valid strobe"}, 32'(st[13:12]), 32'b01);
      chk({nm, " indices"}, 32'(st[11:0]), 32'(exp));
      tick();
      st = status(which);
      chk({nm, " strobe one cycle"}, 32'(st[13:12]), 32'b00);
   endtask

   initial begin
      vec_t vt[5];
      logic [15:0] f;
      logic [11:0] e;

      vt[0] = '{1'b1, 16'h1234, pk(4, 2, 0, 3)};
      vt[1] = '{1'b1, 16'h00FF, pk(4, 3, 2, 1)};
      vt[2] = '{1'b1, 16'hFF00, pk(0, 1, 2, 3)};
      vt[3] = '{1'b0, 16'h0000, pk(0, 1, 2, 3)};
      vt[4] = '{1'b0, 16'hFFFF, pk(0, 1, 2, 3)};

      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; frag0 = '0; frag1 = '0;
      tick(); tick();
      chk("reset dut0", 32'(status(1'b0)), 32'd0);
      chk("reset dut1", 32'(status(1'b1)), 32'd0);
      rst = 1'b0;
      tick();

      // Directed table.
      for (int i = 0; i < 5; i++)
         do_scan(vt[i].which, vt[i].frag, vt[i].exp, 1'b0, $sformatf("vec%0d", i));

      // Extra starts at cycles 2, 6 ignored; start at 7 accepted.
      f = 16'hC3A5;
      e = model(f, 1'b0);
      frag0 = f; start0 = 1'b1;
      tick();
      for (int k = 1; k <= 13; k++) begin
         logic eb, ev;
         start0 = (k == 2 || k == 6 || k == 7);
         tick();
         start0 = 1'b0;
         eb = (k <= 5) || (k >= 7 && k <= 12);
         ev = (k == 6) || (k == 13);
         chk($sformatf("restart c%0d busy/valid", k), 32'({busy0, vld0}), 32'({eb, ev}));
         if (ev) chk($sformatf("restart c%0d indices", k), 32'(out0), 32'(e));
      end
      tick();

      // Reset at cycle 3 of a scan aborts it.
      frag0 = 16'h9E17; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort outputs", 32'(status(1'b0)), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("abort quiet %0d", k), 32'({busy0, vld0}), 32'd0);
      end

      // Input changed during scan.
      do_scan(1'b0, 16'h4B1D, model(16'h4B1D, 1'b0), 1'b1, "latched0");
      do_scan(1'b1, 16'h7E81, model(16'h7E81, 1'b1), 1'b1, "latched1");

      // Randomised fragments against the reference model.
      for (int i = 0; i < 30; i++) begin
         bit w = i[0];
         f = 16'($urandom);
         do_scan(w, f, model(f, w), 1'b0, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/kmer_min_selector.md
KMER_MIN_SELECTOR -- requirements
Module: kmer_min_selector

Interface
REQ-001 The parameters SHALL be (name, default, meaning):
- FRAG_SIZE, 8: bases per fragment.
- BASE_LEN, 2: bits per base.
- FRAG_LEN_BITS, 16: fragment width, equal to FRAG_SIZE*BASE_LEN.
- KMER_SIZE, 4: bases per k-mer.
- INDICES_COUNT, 4: number of minimum positions kept.
- INDICE_LEN, 3: width of a k-mer position index.
- HASH_BITS, 8: hash width.
- HASH_MULT, 157: odd hash multiplier.
- HASH_SEED, 8'h5A: hash XOR seed.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous, active-high.
- in_fragment, in, FRAG_LEN_BITS: packed bases; base b at bits [b*BASE_LEN +: BASE_LEN].
- start, in, 1: single-cycle request to scan in_fragment.
- busy, out, 1: high while a scan is in progress.
- out_kmer_indices, out, INDICES_COUNT x INDICE_LEN: selected positions; slot 0 holds the smallest hash.
- valid_indices, out, 1: one-cycle strobe marking out_kmer_indices as new.
REQ-003 The parameter set SHALL satisfy NUM_KMERS = FRAG_SIZE-KMER_SIZE+1 >= INDICES_COUNT and 2^INDICE_LEN >= NUM_KMERS; the design SHALL check this at elaboration.

Function
REQ-004 The FSM SHALL have three states, with these transitions:
- IDLE to SCAN: on start.
- SCAN to DONE: after the cycle that processes position NUM_KMERS-1.
- DONE to IDLE: unconditionally.
REQ-005 When start is sampled in IDLE, the block SHALL latch in_fragment, clear the position counter to 0, and mark all candidate slots invalid.
REQ-006 The block SHALL ignore start in SCAN and DONE, with no effect on the scan in progress.
REQ-007 In SCAN, each cycle SHALL process one position p, from 0 up to NUM_KMERS-1, using k-mer value kv = latched_fragment[p*BASE_LEN +: KMER_SIZE*BASE_LEN].
REQ-008 The hash SHALL be ((kv * HASH_MULT) mod 2^HASH_BITS) XOR HASH_SEED, as an unsigned product truncated to HASH_BITS.
REQ-009 The candidate list SHALL be INDICES_COUNT {valid, hash, index} slots kept in ascending hash order; an invalid slot compares as larger than any hash.
REQ-010 Each new (hash, p) SHALL be inserted in the same cycle at the first slot whose entry is invalid or strictly greater; the entries below it shift down by one and the last slot is dropped.
REQ-011 Ties SHALL keep the earlier position ahead, i.e. insertion is stable.
REQ-012 In DONE, out_kmer_indices SHALL load slot indices 0..INDICES_COUNT-1 and valid_indices SHALL be high for exactly that one cycle.
REQ-013 Latency SHALL be fixed: with start sampled at cycle 0, valid_indices is high at cycle NUM_KMERS+1 (cycle 6 at defaults).
REQ-014 busy SHALL be high in SCAN and DONE and low in IDLE.
REQ-015 out_kmer_indices SHALL hold its value between DONE strobes.
REQ-016 A start in the same cycle as DONE SHALL be ignored; the next start is accepted in IDLE, so back-to-back scans are spaced NUM_KMERS+2 cycles apart.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL go to state IDLE, clear the position counter, invalidate all slots, and drive busy=0, valid_indices=0 and out_kmer_indices all zero.
REQ-018 rst SHALL take priority over start.
REQ-019 An rst asserted mid-SCAN SHALL abort the scan with no valid_indices strobe.

Structure
REQ-020 The FSM state enum, the candidate-slot struct and the NUM_KMERS/hash helper constants SHALL live in proj_pkg.
REQ-021 One sub-module SHALL be used: kmer_hash, purely combinational, which maps a k-mer value to its hash and is instantiated once.
REQ-022 The list insertion SHALL be a parameterised compare-and-shift array; no multi-cycle sorting.
REQ-023 out_kmer_indices SHALL connect directly to proj_extender's in_kmer_indices, and valid_indices to its valid_indices.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- HASH_MULT=1, HASH_SEED=0, in_fragment=16'h1234, start: hashes per position are 52, 141, 35, 72, 18; at cycle 6, valid_indices=1 and out_kmer_indices={4,2,0,3}, slot 0 first.
- in_fragment=16'h0000, default parameters: all hashes are equal; out_kmer_indices={0,1,2,3}, confirming stable ties.
- start pulsed again at cycles 2 and 6 of a scan: no effect; exactly one strobe at cycle 6; a start at cycle 7 produces a strobe at cycle 13.
- rst asserted at cycle 3 of a scan: at the next edge busy=0 and outputs are zero; no strobe for the next 10 cycles.
- in_fragment changed during SCAN after start: the result matches the latched fragment.
- Randomised fragments compared against a reference model: valid_indices is exactly one cycle wide and busy is low only in IDLE.
